// File: rtl/drctrl_pkg.sv
// Shared types and dual-rail helpers for the clocked dual-rail instruction controller.
// Helpers work on MAX_BITS-wide vectors; callers pass the live bit count.
package drctrl_pkg;

  typedef enum logic {IN_DATA, IN_NULL} in_state_t;

  typedef enum logic [1:0] {OUT_IDLE, OUT_DATA, OUT_RTZ} out_state_t;

  typedef enum logic [1:0] {WF_NULL, WF_DATA, WF_PARTIAL, WF_ILLEGAL} wf_class_t;

  localparam logic [1:0] RAIL_T    = 2'b10;
  localparam logic [1:0] RAIL_F    = 2'b01;
  localparam logic [1:0] RAIL_NULL = 2'b00;

  localparam int MAX_BITS = 32;

  // Pairs at index >= n are ignored, so oversized inputs may be zero-padded.
  function automatic wf_class_t classify(input logic [2*MAX_BITS-1:0] rails, input int n);
    logic any_hi;
    logic all_one;
    logic any_ill;
    any_hi  = 1'b0;
    all_one = 1'b1;
    any_ill = 1'b0;
    for (int k = 0; k < MAX_BITS; k++) begin
      if (k < n) begin
        case (rails[2*k +: 2])
          RAIL_NULL: all_one = 1'b0;
          2'b11:     any_ill = 1'b1;
          default:   any_hi  = 1'b1;
        endcase
      end
    end
    if (any_ill) begin
      return WF_ILLEGAL;
    end else if (!any_hi) begin
      return WF_NULL;
    end else if (all_one) begin
      return WF_DATA;
    end
    return WF_PARTIAL;
  endfunction

  // Command is the top out_bits opcode bits; opcode[k] is the true rail of pair k.
  function automatic logic [MAX_BITS-1:0] decode_cmd(input logic [2*MAX_BITS-1:0] rails,
                                                     input int in_bits, input int out_bits);
    logic [MAX_BITS-1:0] cmd;
    int idx;
    cmd = '0;
    for (int j = 0; j < MAX_BITS; j++) begin
      if (j < out_bits) begin
        idx    = 2 * (in_bits - out_bits + j) + 1;
        cmd[j] = rails[idx];
      end
    end
    return cmd;
  endfunction

  function automatic logic [2*MAX_BITS-1:0] encode(input logic [MAX_BITS-1:0] cmd, input int n);
    logic [2*MAX_BITS-1:0] rails;
    rails = '0;
    for (int k = 0; k < MAX_BITS; k++) begin
      if (k < n) begin
        rails[2*k +: 2] = cmd[k] ? RAIL_T : RAIL_F;
      end
    end
    return rails;
  endfunction

endpackage

// File: rtl/drctrl_fifo.sv
// Small synchronous command FIFO with first-word-fall-through head and registered level.
module drctrl_fifo
  import drctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Over/underflow requests are dropped here so the pointers never corrupt.
  always_comb begin
    do_push  = push && (level_q != LVL_W'(DEPTH));
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/drctrl_sync_stage.sv
// Clocked dual-rail instruction controller: captures settled wavefronts, queues commands,
// replays them four-phase to the cache. Define DRCTRL_ILLEGAL_CNT_EN for the illegal_cnt port.
module drctrl_sync_stage
  import drctrl_pkg::*;
#(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 3,
  parameter int DEPTH    = 2,
  parameter int SETTLE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2*IN_BITS-1:0]        instr_in,
  output logic                        ack,
  output logic [2*OUT_BITS-1:0]       cache_instr,
  input  logic                        cache_ack,
  output logic                        err,
  output logic [$clog2(DEPTH+1)-1:0]  level
`ifdef DRCTRL_ILLEGAL_CNT_EN
  ,
  output logic [7:0]                  illegal_cnt
`endif
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(SETTLE + 1);

  in_state_t             in_state_q, in_state_d;
  out_state_t            out_state_q, out_state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [2*OUT_BITS-1:0] cache_instr_q, cache_instr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic [2*IN_BITS-1:0]  prev_q;
  wf_class_t             wf;
  logic                  stable;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [OUT_BITS-1:0]   wr_cmd;
  logic [OUT_BITS-1:0]   head;

  assign wf     = classify((2*MAX_BITS)'(instr_in), IN_BITS);
  assign wr_cmd = OUT_BITS'(decode_cmd((2*MAX_BITS)'(instr_in), IN_BITS, OUT_BITS));
  assign stable = (wf == WF_DATA) && (instr_in == prev_q);
  assign full   = (level == LVL_W'(DEPTH));

  // Counter saturates at SETTLE so a wavefront held against a full FIFO fires as soon as room appears.
  assign cnt_inc = (cnt_q == CNT_W'(SETTLE)) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    in_state_d = in_state_q;
    ack_d      = ack_q;
    err_d      = err_q;
    cnt_d      = '0;
    push       = 1'b0;
    if (wf == WF_ILLEGAL) begin
      err_d = 1'b1;
    end
    case (in_state_q)
      IN_DATA: begin
        if (stable) begin
          cnt_d = cnt_inc;
          if ((cnt_inc == CNT_W'(SETTLE)) && !full) begin
            push       = 1'b1;
            ack_d      = 1'b1;
            cnt_d      = '0;
            in_state_d = IN_NULL;
          end
        end
      end
      IN_NULL: begin
        if (wf == WF_NULL) begin
          ack_d      = 1'b0;
          in_state_d = IN_DATA;
        end
      end
      default: in_state_d = IN_DATA;
    endcase
  end

  // Cache side only starts a new DATA phase once the previous ack has been released.
  always_comb begin
    out_state_d   = out_state_q;
    cache_instr_d = cache_instr_q;
    pop           = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        cache_instr_d = '0;
        if ((level != '0) && !cache_ack) begin
          cache_instr_d = (2*OUT_BITS)'(encode(MAX_BITS'(head), OUT_BITS));
          out_state_d   = OUT_DATA;
        end
      end
      OUT_DATA: begin
        if (cache_ack) begin
          pop           = 1'b1;
          cache_instr_d = '0;
          out_state_d   = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!cache_ack) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: begin
        cache_instr_d = '0;
        out_state_d   = OUT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q    <= IN_DATA;
      out_state_q   <= OUT_IDLE;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      cache_instr_q <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
    end else begin
      in_state_q    <= in_state_d;
      out_state_q   <= out_state_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      cache_instr_q <= cache_instr_d;
      cnt_q         <= cnt_d;
      prev_q        <= instr_in;
    end
  end

  drctrl_fifo #(
    .WIDTH (OUT_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_cmd),
    .rd_data (head),
    .level   (level)
  );

  assign ack         = ack_q;
  assign err         = err_q;
  assign cache_instr = cache_instr_q;

`ifdef DRCTRL_ILLEGAL_CNT_EN
  logic [7:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if ((wf == WF_ILLEGAL) && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign illegal_cnt = ill_cnt_q;
`endif

endmodule
